// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from the registered table; training from the resolve stage lands next cycle.
module branch_predictor #(
    parameter int XLEN    = 64,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 10,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_next_pc,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_mispred,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [ENTRIES-1:0] valid_vec;
    logic [CTR_W-1:0]   ctr_vec    [ENTRIES];
    logic [TAG_W-1:0]   tag_reg    [ENTRIES];
    logic [XLEN-1:0]    target_reg [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             ctr_we;
    logic [CTR_W-1:0] ctr_cur;
    logic [CTR_W-1:0] ctr_next;

    logic [CNT_W-1:0] br_count_reg;
    logic [CNT_W-1:0] mispred_count_reg;

    // Only the index/tag field of the update PC is consumed.
    logic unused_upd_pc;
    assign unused_upd_pc = ^upd_pc;

    assign lk_idx  = lookup_pc[IDX_W+1:2];
    assign lk_tag  = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    always_comb begin
        pred_hit     = lookup_valid & valid_vec[lk_idx] & (tag_reg[lk_idx] == lk_tag);
        pred_taken   = pred_hit & ctr_vec[lk_idx][CTR_W-1];
        pred_next_pc = pred_taken ? target_reg[lk_idx] : lookup_pc + XLEN'(4);
    end

    assign upd_hit = valid_vec[upd_idx] & (tag_reg[upd_idx] == upd_tag);
    assign ctr_cur = ctr_vec[upd_idx];
    // A not-taken miss leaves the table alone; everything else writes the entry.
    assign ctr_we  = upd_valid & (upd_hit | upd_taken);

    always_comb begin
        ctr_next = ctr_cur;
        if (upd_hit) begin
            if (upd_taken) begin
                ctr_next = (ctr_cur == CTR_MAX) ? ctr_cur : ctr_cur + CTR_W'(1);
            end else begin
                ctr_next = (ctr_cur == '0) ? ctr_cur : ctr_cur - CTR_W'(1);
            end
        end else begin
            ctr_next = CTR_WEAK;
        end
    end

    // Valid bits and counters need reset, so each entry gets its own register.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [CTR_W-1:0] ctr_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    ctr_reg   <= '0;
                end else if (ctr_we && (upd_idx == IDX_W'(gi))) begin
                    valid_reg <= 1'b1;
                    ctr_reg   <= ctr_next;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign ctr_vec[gi]   = ctr_reg;
        end
    endgenerate

    // Tag and target need no reset; rewriting the tag on a hit is harmless.
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            tag_reg[upd_idx]    <= upd_tag;
            target_reg[upd_idx] <= upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_reg      <= '0;
            mispred_count_reg <= '0;
        end else begin
            if (upd_valid && (br_count_reg != CNT_MAX)) begin
                br_count_reg <= br_count_reg + CNT_W'(1);
            end
            if (upd_valid && upd_mispred && (mispred_count_reg != CNT_MAX)) begin
                mispred_count_reg <= mispred_count_reg + CNT_W'(1);
            end
        end
    end

    assign br_count      = br_count_reg;
    assign mispred_count = mispred_count_reg;

endmodule
